// File: rtl/ad9361_ensm_ctrl.sv
`default_nettype none
// ============================================================================
// ad9361_ensm_ctrl : AD9361 pin-mode ENSM sequencer driving ENABLE and TXNRX
// Rev 1.0
// ============================================================================
module ad9361_ensm_ctrl #(
   parameter int LOCK_CYCLES  = 64,
   parameter int SETUP_CYCLES = 4,
   parameter int GUARD_CYCLES = 8,
   parameter int MIN_DWELL    = 16,
   parameter int MAX_DWELL    = 0,
   parameter int TX_PRIORITY  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       lock,
   input  logic       rx_req,
   input  logic       tx_req,
   output logic       enable,
   output logic       txnrx,
   output logic       rx_active,
   output logic       tx_active,
   output logic       busy,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_LOCKWAIT = 3'd0,
      ST_ALERT    = 3'd1,
      ST_SETUP    = 3'd2,
      ST_RX       = 3'd3,
      ST_TX       = 3'd4,
      ST_HOLD     = 3'd5
   } state_t;

   // A nonzero preemption limit shorter than the minimum dwell is raised to it.
   localparam int MAX_EFF = (MAX_DWELL == 0)         ? 0 :
                            (MAX_DWELL < MIN_DWELL)  ? MIN_DWELL : MAX_DWELL;

   localparam logic [15:0] LOCK_LAST  = 16'(LOCK_CYCLES - 1);
   localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYCLES - 1);
   localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYCLES - 1);
   localparam logic [15:0] MIN_LAST   = 16'(MIN_DWELL - 1);
   localparam logic [15:0] MAX_LAST   = 16'(MAX_EFF - 1);
   localparam logic        PREEMPT_EN = (MAX_EFF != 0);
   localparam logic        TX_WINS    = (TX_PRIORITY != 0);

   logic [1:0]  rst_sync;
   logic        run;
   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        dir_q, dir_d;
   logic        pre_q, pre_d;
   logic        own_req, oth_req, preempt, dwell_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign run = rst_sync[1];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dir_d      = dir_q;
      pre_d      = pre_q;
      own_req    = (state_q == ST_TX) ? tx_req : rx_req;
      oth_req    = (state_q == ST_TX) ? rx_req : tx_req;
      preempt    = PREEMPT_EN && oth_req && (cnt_q >= MAX_LAST);
      dwell_done = !own_req && (cnt_q >= MIN_LAST);

      if (!lock) begin
         state_d = ST_LOCKWAIT;
         cnt_d   = 16'd0;
         pre_d   = 1'b0;
      end else begin
         case (state_q)
            ST_LOCKWAIT: begin
               if (cnt_q == LOCK_LAST) begin
                  state_d = ST_ALERT;
                  cnt_d   = 16'd0;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            ST_ALERT: begin
               pre_d = 1'b0;
               if (rx_req || tx_req) begin
                  // Right after a preemption the other direction gets its turn.
                  if (pre_q && (dir_q ? rx_req : tx_req)) begin
                     dir_d = !dir_q;
                  end else if (rx_req && tx_req) begin
                     dir_d = TX_WINS;
                  end else begin
                     dir_d = tx_req;
                  end
                  state_d = ST_SETUP;
                  cnt_d   = SETUP_LAST;
               end
            end
            ST_SETUP: begin
               if (cnt_q == 16'd0) begin
                  state_d = dir_q ? ST_TX : ST_RX;
                  cnt_d   = 16'd0;
               end else begin
                  cnt_d = cnt_q - 16'd1;
               end
            end
            ST_RX, ST_TX: begin
               if (preempt || dwell_done) begin
                  state_d = ST_HOLD;
                  cnt_d   = GUARD_LAST;
                  pre_d   = preempt;
               end else if (cnt_q != 16'hFFFF) begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            ST_HOLD: begin
               if (cnt_q == 16'd0) begin
                  state_d = ST_ALERT;
               end else begin
                  cnt_d = cnt_q - 16'd1;
               end
            end
            default: begin
               state_d = ST_LOCKWAIT;
               cnt_d   = 16'd0;
            end
         endcase
      end
   end

   // Pin outputs are decoded from the next state so they switch with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_LOCKWAIT;
         cnt_q     <= 16'd0;
         dir_q     <= 1'b0;
         pre_q     <= 1'b0;
         enable    <= 1'b0;
         rx_active <= 1'b0;
         tx_active <= 1'b0;
         busy      <= 1'b1;
      end else if (run) begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dir_q     <= dir_d;
         pre_q     <= pre_d;
         enable    <= (state_d == ST_RX) || (state_d == ST_TX);
         rx_active <= (state_d == ST_RX);
         tx_active <= (state_d == ST_TX);
         busy      <= (state_d != ST_ALERT);
      end
   end

   assign txnrx = dir_q;
   assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ad9361_ensm_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ad9361_ensm_ctrl : directed bench with a cycle model for ad9361_ensm_ctrl
// Rev 1.0
// ============================================================================
module tb_ad9361_ensm_ctrl;

   localparam int LOCKC = 64;
   localparam int SETUP = 4;
   localparam int GUARD = 8;
   localparam int MIND  = 16;
   localparam int MAXD  = 32;
   localparam int TXP   = 1;
   localparam int MAXE  = (MAXD == 0) ? 0 : ((MAXD < MIND) ? MIND : MAXD);

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       lock, rx_req, tx_req;
   logic       enable, txnrx, rx_active, tx_active, busy;
   logic [2:0] state;
   logic       b_enable, b_txnrx, b_rx_active, b_tx_active, b_busy;
   logic [2:0] b_state;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ad9361_ensm_ctrl #(
      .LOCK_CYCLES(LOCKC), .SETUP_CYCLES(SETUP), .GUARD_CYCLES(GUARD),
      .MIN_DWELL(MIND), .MAX_DWELL(MAXD), .TX_PRIORITY(TXP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .lock(lock), .rx_req(rx_req), .tx_req(tx_req),
      .enable(enable), .txnrx(txnrx), .rx_active(rx_active),
      .tx_active(tx_active), .busy(busy), .state(state)
   );

   // Second instance differs only in arbitration priority.
   ad9361_ensm_ctrl #(
      .LOCK_CYCLES(LOCKC), .SETUP_CYCLES(SETUP), .GUARD_CYCLES(GUARD),
      .MIN_DWELL(MIND), .MAX_DWELL(MAXD), .TX_PRIORITY(0)
   ) dut_rxp (
      .clk(clk), .rst_n(rst_n), .lock(lock), .rx_req(rx_req), .tx_req(tx_req),
      .enable(b_enable), .txnrx(b_txnrx), .rx_active(b_rx_active),
      .tx_active(b_tx_active), .busy(b_busy), .state(b_state)
   );

   // Model: spec state code, cycles spent in the current state, direction, preempt flag.
   typedef struct packed {
      logic [2:0] st;
      int         age;
      logic       dir;
      logic       pre;
   } mstate_t;

   mstate_t m;
   int      m_rel;

   function automatic mstate_t model_next(mstate_t c, logic lk, logic r, logic t);
      mstate_t n = c;
      logic own, oth;
      n.age = (c.age < 65535) ? c.age + 1 : c.age;
      if (!lk) begin
         n.st  = 3'd0;
         n.age = 0;
         n.pre = 1'b0;
         return n;
      end
      case (c.st)
         3'd0: if (c.age == LOCKC - 1) begin n.st = 3'd1; n.age = 0; end
         3'd1: begin
            n.pre = 1'b0;
            if (r || t) begin
               if (c.pre && (c.dir ? r : t)) n.dir = !c.dir;
               else if (r && t)               n.dir = (TXP != 0);
               else                           n.dir = t;
               n.st  = 3'd2;
               n.age = 0;
            end
         end
         3'd2: if (c.age == SETUP - 1) begin n.st = c.dir ? 3'd4 : 3'd3; n.age = 0; end
         3'd3, 3'd4: begin
            own = (c.st == 3'd4) ? t : r;
            oth = (c.st == 3'd4) ? r : t;
            if (MAXE != 0 && oth && c.age >= MAXE - 1) begin
               n.st = 3'd5; n.age = 0; n.pre = 1'b1;
            end else if (!own && c.age >= MIND - 1) begin
               n.st = 3'd5; n.age = 0;
            end
         end
         3'd5: if (c.age == GUARD - 1) begin n.st = 3'd1; n.age = 0; end
         default: begin n.st = 3'd0; n.age = 0; end
      endcase
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m     <= '0;
         m_rel <= 0;
      end else if (m_rel < 2) begin
         m_rel <= m_rel + 1;
      end else begin
         m <= model_next(m, lock, rx_req, tx_req);
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
      end
   endtask

   always @(negedge clk) begin
      check("model state",     16'(state),     16'(m.st));
      check("model enable",    16'(enable),    16'((m.st == 3'd3) || (m.st == 3'd4)));
      check("model txnrx",     16'(txnrx),     16'(m.dir));
      check("model rx_active", 16'(rx_active), 16'(m.st == 3'd3));
      check("model tx_active", 16'(tx_active), 16'(m.st == 3'd4));
      check("model busy",      16'(busy),      16'(m.st != 3'd1));
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      lock = 1'b0; rx_req = 1'b0; tx_req = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("reset state",  16'(state),  16'd0);
      check("reset enable", 16'(enable), 16'd0);
      check("reset txnrx",  16'(txnrx),  16'd0);
      check("reset busy",   16'(busy),   16'd1);
      tick(3);
      rst_n = 1'b1;
      tick(4);

      // Lock qualification with a one-cycle glitch after 30 cycles.
      lock = 1'b1;
      tick(30);
      lock = 1'b0;
      tick(1);
      lock = 1'b1;
      tick(63);
      check("lock 63 cycles state", 16'(state), 16'd0);
      tick(1);
      check("lock 64 cycles state", 16'(state), 16'd1);
      check("alert busy",           16'(busy),  16'd0);

      // Single TX burst; an RX pulse during SETUP must be ignored.
      tx_req = 1'b1;
      tick(3);
      tx_req = 1'b0;
      rx_req = 1'b1;
      tick(1);
      rx_req = 1'b0;
      check("setup state",  16'(state),  16'd2);
      check("setup enable", 16'(enable), 16'd0);
      check("setup txnrx",  16'(txnrx),  16'd1);
      tick(1);
      check("tx start enable", 16'(enable), 16'd1);
      check("tx start state",  16'(state),  16'd4);
      tick(15);
      check("tx dwell 16 enable", 16'(enable), 16'd1);
      tick(1);
      check("tx end enable", 16'(enable), 16'd0);
      check("tx end state",  16'(state),  16'd5);
      tick(7);
      check("hold last state", 16'(state), 16'd5);
      tick(1);
      check("guard alert state", 16'(state), 16'd1);

      // Simultaneous requests against both priority settings.
      rx_req = 1'b1; tx_req = 1'b1;
      tick(5);
      check("both txprio state",  16'(state),   16'd4);
      check("both txprio txnrx",  16'(txnrx),   16'd1);
      check("both rxprio state",  16'(b_state), 16'd3);
      check("both rxprio txnrx",  16'(b_txnrx), 16'd0);
      check("both rxprio enable", 16'(b_enable), 16'd1);
      rx_req = 1'b0; tx_req = 1'b0;
      tick(40);
      check("both idle state", 16'(state), 16'd1);

      // TX preempted by RX after MAX_DWELL cycles.
      tx_req = 1'b1;
      tick(5);
      check("pre tx state", 16'(state), 16'd4);
      tick(3);
      rx_req = 1'b1;
      tick(28);
      check("pre dwell 32 enable", 16'(enable), 16'd1);
      tick(1);
      check("pre cut enable", 16'(enable), 16'd0);
      check("pre hold txnrx", 16'(txnrx),  16'd1);
      tick(7);
      check("pre hold end txnrx", 16'(txnrx), 16'd1);
      tick(1);
      check("pre alert state", 16'(state), 16'd1);
      tick(1);
      check("pre grant txnrx", 16'(txnrx), 16'd0);
      tx_req = 1'b0;
      tick(4);
      check("rx burst state",  16'(state),  16'd3);
      check("rx burst enable", 16'(enable), 16'd1);

      // Lock loss mid-RX, then requalify into a TX burst.
      tick(5);
      lock = 1'b0;
      tick(1);
      check("lockloss enable", 16'(enable), 16'd0);
      check("lockloss state",  16'(state),  16'd0);
      check("lockloss txnrx",  16'(txnrx),  16'd0);
      lock = 1'b1; rx_req = 1'b0; tx_req = 1'b1;
      tick(63);
      check("relock 63 enable", 16'(enable), 16'd0);
      tick(1);
      check("relock alert", 16'(state), 16'd1);
      tick(5);
      check("relock tx state", 16'(state), 16'd4);

      // Asynchronous reset between clock edges while transmitting.
      tick(3);
      #1 rst_n = 1'b0;
      #1;
      check("async rst enable", 16'(enable),    16'd0);
      check("async rst state",  16'(state),     16'd0);
      check("async rst tx_act", 16'(tx_active), 16'd0);
      check("async rst txnrx",  16'(txnrx),     16'd0);
      tick(2);
      rst_n = 1'b1;
      tick(6);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ad9361_ensm_ctrl.md
AD9361_ENSM_CTRL -- requirements
Module: ad9361_ensm_ctrl

Interface
REQ-001 SHALL have parameter LOCK_CYCLES, default 64: number of consecutive cycles `lock` must stay high before any enable, range 1..65535.
REQ-002 SHALL have parameter SETUP_CYCLES, default 4: number of cycles `txnrx` is held stable before `enable` rises, range 1..65535.
REQ-003 SHALL have parameter GUARD_CYCLES, default 8: number of cycles `enable` stays low after a burst before the next burst, range 1..65535.
REQ-004 SHALL have parameter MIN_DWELL, default 16: minimum number of cycles `enable` stays high per burst, range 1..65535.
REQ-005 SHALL have parameter MAX_DWELL, default 0: preemption limit in cycles when the other direction is requesting; 0 means unlimited.
REQ-006 SHALL have parameter TX_PRIORITY, default 1: 1 means TX wins simultaneous requests, 0 means RX wins.
REQ-007 clk  input  1  single clock for all logic, the interface data clock domain.
REQ-008 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-009 lock  input  1  clock-generator lock from the LVDS interface.
REQ-010 rx_req  input  1  level request for an RX burst.
REQ-011 tx_req  input  1  level request for a TX burst.
REQ-012 enable  output  1  AD9361 ENABLE pin, registered.
REQ-013 txnrx  output  1  AD9361 TXNRX pin, registered; 1 = TX.
REQ-014 rx_active  output  1  high while in state RX, registered.
REQ-015 tx_active  output  1  high while in state TX, registered.
REQ-016 busy  output  1  high in any state other than ALERT, registered.
REQ-017 state  output  3  encoded state: LOCKWAIT=0, ALERT=1, SETUP=2, RX=3, TX=4, HOLD=5.

Function
REQ-018 SHALL use one 16-bit down/up counter `cnt` shared across states, plus a 1-bit `dir` register that drives `txnrx`.
REQ-019 LOCKWAIT: enable=0; `cnt` increments while lock=1 and clears when lock=0; go to ALERT when cnt==LOCK_CYCLES-1 and lock=1.
REQ-020 ALERT: enable=0; if exactly one request is high, latch `dir` from it; if both are high, latch `dir`=TX_PRIORITY; load cnt=SETUP_CYCLES-1; go to SETUP.
REQ-021 ALERT with no request: stay in ALERT; `dir` and `txnrx` hold their previous values.
REQ-022 SETUP: enable=0, txnrx=dir; decrement `cnt`; at cnt==0 go to TX (dir=1) or RX (dir=0); `enable` goes high on the same clock edge as the state register.
REQ-023 RX/TX: enable=1; `cnt` counts up from 0, saturating at 65535.
REQ-024 RX/TX exit condition: the own request is low and cnt>=MIN_DWELL-1; on exit go to HOLD, load cnt=GUARD_CYCLES-1, and set enable=0.
REQ-025 RX/TX preemption: MAX_DWELL!=0, the other request is high, and cnt>=MAX_DWELL-1 forces the HOLD transition even if the own request is still high.
REQ-026 MAX_DWELL shall be clamped to no less than MIN_DWELL.
REQ-027 HOLD: enable=0, txnrx unchanged; decrement `cnt`; at cnt==0 go to ALERT.
REQ-028 After preemption, the return to ALERT SHALL grant the other direction: in the first ALERT cycle after a preempted burst, ignore the preempted direction if the other request is high.
REQ-029 `txnrx` SHALL change only on the ALERT->SETUP transition; `txnrx` never toggles while enable=1 or within GUARD_CYCLES after `enable` falls.
REQ-030 Loss of lock (lock=0) in any state except LOCKWAIT: next edge goes to LOCKWAIT, enable=0, cnt=0, txnrx held.
REQ-031 Requests are sampled only in ALERT, RX and TX; pulses in other states are ignored, not queued.
REQ-032 Minimum request-to-enable latency is SETUP_CYCLES+1 cycles from rx_req/tx_req high in ALERT.

Reset
REQ-033 rst_n=0 SHALL asynchronously force state=LOCKWAIT, cnt=0, dir=0, enable=0, txnrx=0, rx_active=0, tx_active=0, busy=1.
REQ-034 rst_n deassertion SHALL be synchronized internally by a 2-flop synchronizer; the FSM first advances 2 edges after release.

Verification
REQ-035 Lock handling: lock=1 after reset, defaults -> ALERT reached after 64 cycles of lock; a lock glitch at cycle 30 restarts the 64-cycle count.
REQ-036 Single TX burst: tx_req held 3 cycles in ALERT -> txnrx=1, enable high 5 cycles after request, high exactly 16 cycles (MIN_DWELL), then low; ALERT reached 8 cycles later.
REQ-037 Simultaneous requests: rx_req=tx_req=1 in ALERT with TX_PRIORITY=1 -> TX burst first; with TX_PRIORITY=0 -> RX burst first.
REQ-038 Preemption: MAX_DWELL=32, tx_req held constantly, rx_req raised -> enable falls when the TX burst reaches 32 cycles; the next burst is RX with txnrx=0; txnrx is stable during HOLD.
REQ-039 Lock loss mid-RX: lock=0 while enable=1 -> enable=0 on the next edge, state=LOCKWAIT, no burst until lock has been high for 64 cycles.
REQ-040 Async reset mid-TX: rst_n=0 between clock edges -> enable=0 and state=0 immediately, with no clock edge needed.
